csr_access_sequencer: RTL and testbench

- Sits between the decode/execute stage and the CSR register file. It is directly upstream of the CSR file.
- Accepts one Zicsr instruction at a time (CSRRW/RS/RC and their immediate forms), reads the old CSR value, computes the new value, and drives a single-cycle write strobe.
- Waits for the CSR file's write_done, then returns the old value as the rd writeback result.
- Stalls the pipeline through req_ready/busy while an access is in flight.

---
 rtl/csr_access_sequencer_pkg.sv | 43 ++++
 rtl/csr_access_sequencer_value_alu.sv | 42 ++++
 rtl/csr_access_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_csr_access_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_access_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : csr_pkg
// Description : Shared Zicsr encodings, sequencer state encoding, CSR address
//               constants and the read-only-space predicate.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_pkg;

    localparam logic [2:0] CSRRW  = 3'b001;
    localparam logic [2:0] CSRRS  = 3'b010;
    localparam logic [2:0] CSRRC  = 3'b011;
    localparam logic [2:0] CSRRWI = 3'b101;
    localparam logic [2:0] CSRRSI = 3'b110;
    localparam logic [2:0] CSRRCI = 3'b111;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // addr[11:10] == 2'b11 is exactly the range 0xC00..0xFFF
    function automatic logic is_read_only(input logic [11:0] addr);
        return (addr >= 12'hC00);
    endfunction

    function automatic logic is_legal_func3(input logic [2:0] f3);
        return !((f3 == 3'b000) || (f3 == 3'b100));
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_access_sequencer_value_alu.sv
`default_nettype none
// ============================================================================
// Module      : csr_value_alu
// Description : Combinational new-value and write-intent computation for
//               CSRRW/RS/RC and their immediate forms.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_value_alu
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] src,
    input  logic [4:0]      rs1_idx,
    output logic [XLEN-1:0] new_val,
    output logic            write_intent
);

    always_comb begin
        new_val      = old;
        write_intent = 1'b0;
        case (func3)
            CSRRW, CSRRWI: begin
                new_val      = src;
                write_intent = 1'b1;
            end
            CSRRS, CSRRSI: begin
                new_val      = old | src;
                write_intent = (rs1_idx != 5'd0);
            end
            CSRRC, CSRRCI: begin
                new_val      = old & ~src;
                write_intent = (rs1_idx != 5'd0);
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/csr_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : csr_access_sequencer
// Description : Sequences one Zicsr access (read, compute, strobe, wait done,
//               respond). Optional WAIT timeout via CSR_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_access_sequencer
    import csr_pkg::*;
#(
    parameter int XLEN = 32
`ifdef CSR_SEQ_TIMEOUT_EN
    ,
    parameter int WR_TIMEOUT = 15
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_func3,
    input  logic [11:0]     req_csr_addr,
    input  logic [XLEN-1:0] req_rs1_data,
    input  logic [4:0]      req_rs1_idx,
    input  logic [4:0]      req_rd,
    output logic [11:0]     csr_addr,
    output logic [2:0]      csr_func3,
    output logic [4:0]      csr_imm,
    input  logic [XLEN-1:0] csr_rdata,
    output logic [XLEN-1:0] csr_wdata,
    output logic            csr_write_enable,
    input  logic            csr_write_done,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [4:0]      resp_rd,
    output logic [XLEN-1:0] resp_rd_data,
    output logic            resp_rd_we,
    output logic            resp_illegal,
    output logic            busy
);

    state_e            state_q, state_d;
    logic [2:0]        func3_q, func3_d;
    logic [11:0]       addr_q, addr_d;
    logic [4:0]        imm_q, imm_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [XLEN-1:0]   old_q, old_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              illegal_q, illegal_d;

    logic [XLEN-1:0]   w_src;
    logic [XLEN-1:0]   w_new;
    logic              w_write_intent;
    logic              w_illegal;

`ifdef CSR_SEQ_TIMEOUT_EN
    localparam int TMO_W = ($clog2(WR_TIMEOUT) < 4) ? 4 : $clog2(WR_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WR_TIMEOUT - 1);
    logic [TMO_W-1:0]  tmo_q, tmo_d;
`endif

    // Immediate forms use the rs1 field as a zero-extended uimm
    assign w_src = func3_q[2] ? {{(XLEN-5){1'b0}}, imm_q} : rs1_q;

    csr_value_alu #(.XLEN(XLEN)) u_alu (
        .func3        (func3_q),
        .old          (csr_rdata),
        .src          (w_src),
        .rs1_idx      (imm_q),
        .new_val      (w_new),
        .write_intent (w_write_intent)
    );

    assign w_illegal = !is_legal_func3(func3_q) ||
                       (w_write_intent && is_read_only(addr_q));

    always_comb begin
        state_d   = state_q;
        func3_d   = func3_q;
        addr_d    = addr_q;
        imm_d     = imm_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        old_d     = old_q;
        wdata_d   = wdata_q;
        illegal_d = illegal_q;
`ifdef CSR_SEQ_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    func3_d   = req_func3;
                    addr_d    = req_csr_addr;
                    imm_d     = req_rs1_idx;
                    rd_d      = req_rd;
                    rs1_d     = req_rs1_data;
                    illegal_d = 1'b0;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                old_d     = csr_rdata;
                wdata_d   = w_new;
                illegal_d = w_illegal;
                state_d   = (!w_illegal && w_write_intent) ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
`ifdef CSR_SEQ_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = csr_write_done ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (csr_write_done) begin
                    state_d = ST_RESP;
                end
`ifdef CSR_SEQ_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    illegal_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            func3_q   <= '0;
            addr_q    <= '0;
            imm_q     <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            old_q     <= '0;
            wdata_q   <= '0;
            illegal_q <= 1'b0;
`ifdef CSR_SEQ_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            func3_q   <= func3_d;
            addr_q    <= addr_d;
            imm_q     <= imm_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            old_q     <= old_d;
            wdata_q   <= wdata_d;
            illegal_q <= illegal_d;
`ifdef CSR_SEQ_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    // Strobe and valid decode straight from state so reset drops them at once
    assign req_ready        = (state_q == ST_IDLE);
    assign busy             = (state_q != ST_IDLE);
    assign csr_write_enable = (state_q == ST_WRITE);
    assign resp_valid       = (state_q == ST_RESP);
    assign csr_addr         = addr_q;
    assign csr_func3        = func3_q;
    assign csr_imm          = imm_q;
    assign csr_wdata        = wdata_q;
    assign resp_rd          = rd_q;
    assign resp_rd_data     = old_q;
    assign resp_illegal     = illegal_q;
    assign resp_rd_we       = (rd_q != 5'd0) && !illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_access_sequencer
// Description : Table-driven scoreboard bench for csr_access_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_access_sequencer;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_func3 = '0;
    logic [11:0] req_csr_addr = '0;
    logic [31:0] req_rs1_data = '0;
    logic [4:0]  req_rs1_idx = '0;
    logic [4:0]  req_rd = '0;
    logic [11:0] csr_addr;
    logic [2:0]  csr_func3;
    logic [4:0]  csr_imm;
    logic [31:0] csr_rdata = '0;
    logic [31:0] csr_wdata;
    logic        csr_write_enable;
    logic        csr_write_done;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [4:0]  resp_rd;
    logic [31:0] resp_rd_data;
    logic        resp_rd_we;
    logic        resp_illegal;
    logic        busy;

    logic        same_mode = 1'b0;
    logic        done_r = 1'b0;
    assign csr_write_done = (same_mode & csr_write_enable) | done_r;

    csr_access_sequencer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_func3(req_func3),
        .req_csr_addr(req_csr_addr), .req_rs1_data(req_rs1_data),
        .req_rs1_idx(req_rs1_idx), .req_rd(req_rd),
        .csr_addr(csr_addr), .csr_func3(csr_func3), .csr_imm(csr_imm),
        .csr_rdata(csr_rdata), .csr_wdata(csr_wdata),
        .csr_write_enable(csr_write_enable), .csr_write_done(csr_write_done),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd),
        .resp_rd_data(resp_rd_data), .resp_rd_we(resp_rd_we),
        .resp_illegal(resp_illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  func3;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [4:0]  idx;
        logic [4:0]  rd;
        logic [31:0] old;
        bit          same;
        bit          nodone;
        int          hold;
        bit          exp_we;
        logic [31:0] exp_wdata;
        bit          exp_rd_we;
        bit          exp_ill;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] rd_data;
        bit          rd_we;
        bit          ill;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[13];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [2:0] f, logic [11:0] a, logic [31:0] r,
                                logic [4:0] i, logic [4:0] d, logic [31:0] o,
                                bit s, int h, bit we, logic [31:0] wd,
                                bit rwe, bit ill, int lat);
        vec_t v;
        v.func3 = f; v.addr = a; v.rs1 = r; v.idx = i; v.rd = d; v.old = o;
        v.same = s; v.nodone = 1'b0; v.hold = h; v.exp_we = we;
        v.exp_wdata = wd; v.exp_rd_we = rwe; v.exp_ill = ill; v.exp_lat = lat;
        return v;
    endfunction

    // Entered just after a rising edge with the DUT idle; leaves at a falling edge.
    task automatic run_txn(input vec_t v);
        exp_t e, g;
        bit   got;
        bit   pend;
        int   strobes;
        req_valid    = 1'b1;
        req_func3    = v.func3;
        req_csr_addr = v.addr;
        req_rs1_data = v.rs1;
        req_rs1_idx  = v.idx;
        req_rd       = v.rd;
        csr_rdata    = v.old;
        same_mode    = v.same;
        @(negedge clk);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        e.rd = v.rd; e.rd_data = v.old; e.rd_we = v.exp_rd_we; e.ill = v.exp_ill;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid    = 1'b0;
        req_rs1_data = $urandom;
        req_rs1_idx  = 5'($urandom);
        req_csr_addr = 12'($urandom);
        got = 1'b0; pend = 1'b0; strobes = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            done_r = pend;
            pend   = 1'b0;
            @(negedge clk);
            if (k == 1) begin
                chk("csr_addr_held", {20'b0, csr_addr}, {20'b0, v.addr});
                chk("csr_func3", {29'b0, csr_func3}, {29'b0, v.func3});
                chk("csr_imm", {27'b0, csr_imm}, {27'b0, v.idx});
                chk("busy_read", {31'b0, req_ready, busy}, 32'd1);
            end
            if (csr_write_enable) begin
                strobes++;
                chk("csr_wdata", csr_wdata, v.exp_wdata);
                if (!v.same && !v.nodone) pend = 1'b1;
            end
            if (resp_valid) begin
                got = 1'b1;
                chk("resp_latency", k, v.exp_lat);
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    g = sb.pop_front();
                    chk("resp_rd", {27'b0, resp_rd}, {27'b0, g.rd});
                    chk("resp_rd_data", resp_rd_data, g.rd_data);
                    chk("resp_rd_we", {31'b0, resp_rd_we}, {31'b0, g.rd_we});
                    chk("resp_illegal", {31'b0, resp_illegal}, {31'b0, g.ill});
                end
                for (int h = 0; h < v.hold; h++) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                    chk("hold_valid", {31'b0, resp_valid}, 32'd1);
                    chk("hold_rd_data", resp_rd_data, v.old);
                    chk("hold_illegal", {31'b0, resp_illegal}, {31'b0, v.exp_ill});
                    chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
                end
                resp_ready = 1'b1;
                @(posedge clk); #1;
                resp_ready = 1'b0;
                @(negedge clk);
                chk("post_resp_ready", {31'b0, req_ready}, 32'd1);
                chk("post_resp_valid", {31'b0, resp_valid}, 32'd0);
            end else begin
                @(posedge clk); #1;
            end
        end
        done_r    = 1'b0;
        same_mode = 1'b0;
        if (!got) begin
            chk("resp_timeout", 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        chk("strobe_count", strobes, {31'b0, v.exp_we});
    endtask

    initial begin
        //            func3   addr    rs1           idx   rd    old          s h we wdata         rwe ill lat
        tbl[0]  = mk(CSRRW,  12'h340, 32'hDEADBEEF, 5'd1, 5'd5, 32'h0,       0,0,1,32'hDEADBEEF, 1, 0, 4);
        tbl[1]  = mk(CSRRS,  12'h300, 32'h12345678, 5'd0, 5'd3, 32'h88,      0,0,0,32'h0,        1, 0, 2);
        tbl[2]  = mk(CSRRCI, 12'h304, 32'h0,        5'd5, 5'd7, 32'hF,       0,0,1,32'hA,        1, 0, 4);
        tbl[3]  = mk(CSRRSI, 12'h304, 32'hFFFFFFFF, 5'd3, 5'd8, 32'h8,       0,0,1,32'hB,        1, 0, 4);
        tbl[4]  = mk(CSRRW,  12'hC00, 32'h1,        5'd2, 5'd4, 32'h55,      0,0,0,32'h0,        0, 1, 2);
        tbl[5]  = mk(3'b100, 12'h340, 32'h1,        5'd1, 5'd6, 32'h11,      0,0,0,32'h0,        0, 1, 2);
        tbl[6]  = mk(CSRRC,  12'h341, 32'h0000FF00, 5'd9, 5'd10,32'h1234FFFF,0,0,1,32'h123400FF, 1, 0, 4);
        tbl[7]  = mk(CSRRS,  12'h342, 32'hF0000000, 5'd4, 5'd0, 32'h0F,      0,0,1,32'hF000000F, 0, 0, 4);
        tbl[8]  = mk(CSRRWI, 12'h305, 32'hFFFFFFFF, 5'd0, 5'd2, 32'h77,      0,0,1,32'h0,        1, 0, 4);
        tbl[9]  = mk(CSRRS,  12'hC00, 32'h0,        5'd0, 5'd1, 32'hC0FFEE,  0,0,0,32'h0,        1, 0, 2);
        tbl[10] = mk(CSRRW,  12'h340, 32'hA5A5A5A5, 5'd1, 5'd11,32'h1,       1,0,1,32'hA5A5A5A5, 1, 0, 3);
        tbl[11] = mk(3'b000, 12'h300, 32'h3,        5'd3, 5'd12,32'h99,      0,0,0,32'h0,        0, 1, 2);
        tbl[12] = mk(CSRRCI, 12'h300, 32'h0,        5'd31,5'd13,32'hFFFFFFFF,0,5,1,32'hFFFFFFE0, 1, 0, 4);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_we", {31'b0, csr_write_enable}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_csr_addr", {20'b0, csr_addr}, 32'd0);
        chk("rst_wdata", csr_wdata, 32'd0);
        chk("rst_rd_data", resp_rd_data, 32'd0);
        chk("rst_illegal", {31'b0, resp_illegal}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Stray done pulse while idle must not start anything
        done_r = 1'b1;
        @(posedge clk); #1;
        done_r = 1'b0;
        @(negedge clk);
        chk("stray_done_busy", {31'b0, busy}, 32'd0);
        chk("stray_done_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            run_txn(tbl[i]);
            @(posedge clk); #1;
        end

        // Reset during WRITE (s=2) and during WAIT (s=3)
        for (int s = 2; s <= 3; s++) begin
            req_valid = 1'b1; req_func3 = CSRRW; req_csr_addr = CSR_MSCRATCH;
            req_rs1_data = 32'h5; req_rs1_idx = 5'd1; req_rd = 5'd5; csr_rdata = 32'h0;
            @(posedge clk); #1;
            req_valid = 1'b0;
            for (int k = 1; k < s; k++) @(posedge clk);
            #1;
            @(negedge clk);
            chk("pre_rst_we", {31'b0, csr_write_enable}, (s == 2) ? 32'd1 : 32'd0);
            chk("pre_rst_busy", {31'b0, busy}, 32'd1);
            #2 reset = 1'b0;
            #1;
            chk("mid_rst_we", {31'b0, csr_write_enable}, 32'd0);
            chk("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
            chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
            @(posedge clk); #1;
            reset = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("post_rst_valid", {31'b0, resp_valid}, 32'd0);
                chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
            end
            @(posedge clk); #1;
        end

`ifdef CSR_SEQ_TIMEOUT_EN
        begin
            vec_t tv;
            tv = mk(CSRRW, 12'h340, 32'h1, 5'd1, 5'd5, 32'h0, 0, 0, 1, 32'h1, 0, 1, 18);
            tv.nodone = 1'b1;
            run_txn(tv);
            @(posedge clk); #1;
        end
`endif

        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
